// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: command port and 4-wire SPI pins of spi_master_ctrl
//  cmd_valid/cmd_ready/cmd_word : command handshake (10-bit word)
//  rd_data/rd_valid             : read-data result
//  busy/proto_err               : status
//  SS_n/MOSI/MISO               : SPI link to the slave
//  modport master = controller side, modport slave = command user / link peer side
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_word;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       proto_err;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  modport master (
    input  cmd_valid, cmd_word, MISO,
    output cmd_ready, rd_data, rd_valid, busy, proto_err, SS_n, MOSI
  );
  modport slave (
    output cmd_valid, cmd_word, MISO,
    input  cmd_ready, rd_data, rd_valid, busy, proto_err, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master framing 10-bit command words, capturing 8-bit MISO replies for read-data
//  Ports: clk, rst (async active-high), bus (spi_master_ctrl_if.master: command handshake,
//         rd_data/rd_valid, busy, proto_err, SS_n/MOSI/MISO)
//  Parameters: RD_WAIT (cycles between last payload bit and first MISO bit), IDLE_GAP (SS_n-high END cycles)
//  Option: SPI_MASTER_ORDER_CHK_EN rejects read-data before any read-addr frame with a proto_err pulse
module spi_master_ctrl #(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input logic clk,
  input logic rst,
  spi_master_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT_OUT, S_WAIT, S_SHIFT_IN, S_END, S_ERR} state_t;
  state_t state, nxt;
  logic [4:0] cnt, nxt_cnt, idx;
  logic [9:0] word_q, word_n;
  logic [7:0] shreg;
  logic       ss_d, mosi_d, rd_done;
`ifdef SPI_MASTER_ORDER_CHK_EN
  logic addr_seen;
`endif
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt + 5'd1;
    word_n  = word_q;
    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        if (bus.cmd_valid) begin
          word_n = bus.cmd_word;
`ifdef SPI_MASTER_ORDER_CHK_EN
          nxt = (bus.cmd_word[9:8] == 2'b11 && !addr_seen) ? S_ERR : S_SHIFT_OUT;
`else
          nxt = S_SHIFT_OUT;
`endif
        end
      end
      S_SHIFT_OUT:
        if (cnt == 5'd11) begin
          nxt_cnt = '0;
          nxt = word_q[9:8] != 2'b11 ? S_END : (RD_WAIT == 0 ? S_SHIFT_IN : S_WAIT);
        end
      S_WAIT:
        if (cnt == 5'(RD_WAIT - 1)) begin
          nxt_cnt = '0;
          nxt = S_SHIFT_IN;
        end
      S_SHIFT_IN:
        if (cnt == 5'd7) begin
          nxt_cnt = '0;
          nxt = S_END;
        end
      S_END:
        if (cnt >= 5'(IDLE_GAP - 1)) begin
          nxt_cnt = '0;
          nxt = S_IDLE;
        end
      default: begin
        nxt_cnt = '0;
        nxt = S_IDLE;
      end
    endcase
    // outputs are registered, so they are derived from the state/count of the coming cycle
    idx     = 5'd11 - nxt_cnt;
    mosi_d  = nxt == S_SHIFT_OUT ? (nxt_cnt < 5'd3 ? word_n[9] : word_n[idx[3:0]]) : 1'b0;
    ss_d    = !(nxt == S_SHIFT_OUT || nxt == S_WAIT || nxt == S_SHIFT_IN);
    rd_done = state == S_SHIFT_IN && nxt == S_END;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      word_q       <= '0;
      shreg        <= '0;
      bus.SS_n     <= 1'b1;
      bus.MOSI     <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= nxt_cnt;
      word_q       <= word_n;
      shreg        <= state == S_SHIFT_IN ? {shreg[6:0], bus.MISO} : shreg;
      bus.SS_n     <= ss_d;
      bus.MOSI     <= mosi_d;
      bus.rd_data  <= rd_done ? {shreg[6:0], bus.MISO} : bus.rd_data;
      bus.rd_valid <= rd_done;
    end
`ifdef SPI_MASTER_ORDER_CHK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_seen     <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      addr_seen     <= addr_seen | (state == S_SHIFT_OUT && nxt == S_END && word_q[9:8] == 2'b10);
      bus.proto_err <= nxt == S_ERR;
    end
`else
  assign bus.proto_err = 1'b0;
`endif
  assign bus.cmd_ready = state == S_IDLE;
  assign bus.busy      = state != S_IDLE;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench decoding SPI frames off SS_n/MOSI and modelling the slave's MISO reply
module tb_spi_master_ctrl;
  typedef struct {
    logic [9:0] w;
    int         len;
    bit         rd;
    logic [7:0] b;
  } frame_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  frame_t exp_q[$];
  logic [7:0] rd_q[$];
  logic bits [0:31];
  int fcnt = 0;
  int hcnt = 0;
  bit bb = 0;
  spi_master_ctrl_if bus ();
  spi_master_ctrl #(.RD_WAIT(2), .IDLE_GAP(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic finish_frame();
    frame_t e;
    logic [9:0] w;
    logic pad;
    if (exp_q.size() == 0) begin
      check("frame_unexpected", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("frame_len", fcnt, e.len);
    check("rd_valid_end", bus.rd_valid, e.rd);
    check("proto_err_frame", bus.proto_err, 0);
    if (e.len >= 12 && fcnt >= 12) begin
      w[9] = bits[0];
      for (int i = 3; i < 12; i++) w[11 - i] = bits[i];
      check("frame_word", w, e.w);
      check("mosi_pre", {bits[1], bits[2]}, {e.w[9], e.w[9]});
      pad = 1'b0;
      for (int i = 12; i < fcnt && i < 32; i++) pad = pad | bits[i];
      check("mosi_pad", pad, 0);
    end
  endtask
  always @(negedge clk) begin
    if (bus.SS_n === 1'b0) begin
      if (fcnt == 0 && bb) begin
        check("b2b_gap", hcnt, 2);
        bb = 0;
      end
      if (fcnt < 32) bits[fcnt] = bus.MOSI;
      bus.MISO = (fcnt >= 14 && fcnt <= 21 && exp_q.size() > 0) ? exp_q[0].b[21 - fcnt] : 1'b0;
      fcnt++;
      hcnt = 0;
    end else begin
      if (fcnt > 0) finish_frame();
      fcnt = 0;
      hcnt++;
      bus.MISO = 1'b0;
    end
    if (bus.rd_valid === 1'b1) begin
      if (rd_q.size() == 0) check("rd_spurious", 1, 0);
      else check("rd_data", bus.rd_data, rd_q.pop_front());
    end
  end
  task automatic send(input logic [9:0] w, input int len, input logic [7:0] b, input int lat);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = w;
    if (len > 0) exp_q.push_back('{w: w, len: len, rd: len == 22, b: b});
    if (len == 22) rd_q.push_back(b);
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = 10'($urandom);
    if (lat > 0) begin
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("ready_latency", n, lat);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    bus.MISO      = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_ss", bus.SS_n, 1);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_proto_err", bus.proto_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef SPI_MASTER_ORDER_CHK_EN
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = 10'h300;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("err_pulse", bus.proto_err, 1);
    check("err_ss", bus.SS_n, 1);
    @(posedge clk);
    #1;
    check("err_clear", bus.proto_err, 0);
    check("err_ready", bus.cmd_ready, 1);
    send(10'h27E, 12, 8'h00, 13);
`endif
    send(10'b00_1010_0101, 12, 8'h00, 13);
    send(10'b11_0000_0000, 22, 8'hC3, 23);
    send(10'b11_0101_1010, 22, 8'h5A, 23);
    for (int i = 0; i < 3; i++) send({2'b01, 8'($urandom)}, 12, 8'h00, 13);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = 10'h0F3;
    exp_q.push_back('{w: 10'h0F3, len: 12, rd: 1'b0, b: 8'h00});
    exp_q.push_back('{w: 10'h2A6, len: 12, rd: 1'b0, b: 8'h00});
    @(posedge clk);
    #1;
    bus.cmd_word = 10'h2A6;
    @(posedge clk);
    #1;
    bb = 1;
    for (int n = 0; n < 100 && bus.cmd_ready !== 1'b1; n++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    check("b2b_seen", bb, 0);
    send(10'b11_1111_0000, 6, 8'hFF, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_ss", bus.SS_n, 1);
    check("abort_rd_valid", bus.rd_valid, 0);
    check("abort_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(10'b00_1010_0101, 12, 8'h00, 13);
    repeat (5) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
